instr_mem_loadable: RTL and testbench
=====================================

Name: instr_mem_loadable

Overview:
- Parametrised, synthesisable instruction memory for the single-cycle and future multi-cycle CPUs.
- Replaces hard-coded program contents with a runtime load port. Programs are streamed in word by word over a valid/ready handshake after a reset-time clear.
- Fetch is registered: one-cycle read latency, with valid and address-fault flags.
- Sits between the PC register and the decoder. The load port is driven by the testbench or a boot loader.

Parameters:
- WIDTH, 16, instruction word width in bits
- DEPTH, 16, number of words; power of two, at least 2
- PC_WIDTH, 16, program counter width
- ADDR_LSB, 1, log2 of bytes per word; word index = pc[ADDR_LSB+log2(DEPTH)-1 : ADDR_LSB]
- NOP, 0 (WIDTH bits), word used for clear fill and for fault responses

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- fetch_req  in  1  request instruction at pc this cycle
- pc  in  PC_WIDTH  byte address
- instruction  out  WIDTH  registered fetch result
- instr_valid  out  1  instruction is valid this cycle
- addr_fault  out  1  the completed fetch was out of range or misaligned
- load_start  in  1  begin a program load at word 0
- load_valid  in  1  load_data carries a word
- load_last  in  1  qualifies the final word of a load
- load_data  in  WIDTH  program word
- load_ready  out  1  block accepts load words
- load_done  out  1  one-cycle pulse when a load completes
- busy  out  1  high in CLEAR or LOAD; fetches are ignored

Behaviour:
- Reset (sampled at a clk edge) values:
  - FSM = CLEAR, clear/write pointer = 0
  - instruction = NOP; instr_valid, addr_fault, load_ready, load_done = 0; busy = 1
- Reset overrides everything, including a load in progress. The partially loaded image is discarded by the clear.
- CLEAR state:
  - Writes NOP to mem[ptr] each cycle and increments ptr.
  - After writing DEPTH-1 (exactly DEPTH cycles), go to READY with ptr = 0.
- READY state:
  - busy = 0, load_ready = 0.
  - load_start: go to LOAD next cycle with ptr = 0. load_valid is ignored in READY.
- LOAD state:
  - busy = 1, load_ready = 1.
  - Transfer occurs when load_valid and load_ready are both high: mem[ptr] = load_data, then ptr increments.
  - The load ends on the transfer with load_last = 1, or on the transfer to ptr = DEPTH-1, whichever comes first. load_done pulses high in the following cycle and the FSM returns to READY; load_ready is low from that cycle.
  - Words beyond the last loaded word keep their prior contents.
  - load_start during LOAD is ignored.
- Fetch (READY only):
  - On fetch_req, the next cycle has instr_valid = 1.
  - Fault when pc >= DEPTH << ADDR_LSB, or pc[ADDR_LSB-1:0] != 0. Then instruction = NOP and addr_fault = 1.
  - Otherwise instruction = mem[index] and addr_fault = 0.
  - Latency is exactly 1 cycle. Back-to-back fetches are supported, one per cycle.
  - Without fetch_req: instr_valid = 0, addr_fault = 0, and instruction holds its last value.
- Fetch while busy: fetch_req is ignored, instr_valid = 0, instruction holds.
- fetch_req and load_start in the same READY cycle: the fetch is serviced (valid next cycle) and LOAD is entered. The fetch reads pre-load contents.
- Storage is a single-write-port, single-read-port array. Writes happen only in CLEAR and LOAD, so there are no read/write collisions.
- All outputs are registered; no combinational path from inputs to outputs, except load_ready, which is decoded from FSM state only.

Test Plan:
- Reset then wait 16 cycles: busy is 1 for cycles 1-16 and 0 at cycle 17. Fetches at pc = 0x0000 and 0x001E return 0x0000, instr_valid = 1, addr_fault = 0.
- Load 0x8180, 0x0530, 0xDC67 with load_last on the third word, inserting a load_valid gap of 2 cycles: exactly 3 transfers, load_done pulses once, busy drops. Fetches at pc = 0, 2, 4 return 0x8180, 0x0530, 0xDC67 one cycle after each request. pc = 6 returns 0x0000.
- Fetch at pc = 0x0020 returns NOP with addr_fault = 1. Fetch at pc = 0x0003 gives addr_fault = 1. Fetch at pc = 0x0002 gives addr_fault = 0.
- Load 16 words 0x1000..0x100F without load_last: load ends after the 16th word and load_ready drops. Fetch at pc = 0x1E returns 0x100F.
- Assert rst after 5 load words: the block is busy for 16 clear cycles, then every fetch in pc 0..0x1E returns 0x0000.
- fetch_req with load_start at pc = 2 (holding 0x0530), then reload word 1 as 0xFFFF: the first fetch returns 0x0530, fetches during LOAD give instr_valid = 0, and a post-load fetch at pc = 2 returns 0xFFFF.

Source files
------------

// File: rtl/instr_mem_loadable_if.sv
// rtl/instr_mem_loadable_if.sv - fetch and program-load port bundle for instr_mem_loadable
interface instr_mem_loadable_if #(
  parameter int WIDTH    = 16,
  parameter int PC_WIDTH = 16
);
  logic                fetch_req;
  logic [PC_WIDTH-1:0] pc;
  logic [WIDTH-1:0]    instruction;
  logic                instr_valid;
  logic                addr_fault;
  logic                load_start;
  logic                load_valid;
  logic                load_last;
  logic [WIDTH-1:0]    load_data;
  logic                load_ready;
  logic                load_done;
  logic                busy;

  // PC register / boot loader side
  modport master (
    output fetch_req, pc, load_start, load_valid, load_last, load_data,
    input  instruction, instr_valid, addr_fault, load_ready, load_done, busy
  );

  // memory side
  modport slave (
    input  fetch_req, pc, load_start, load_valid, load_last, load_data,
    output instruction, instr_valid, addr_fault, load_ready, load_done, busy
  );
endinterface

// File: rtl/instr_mem_loadable.sv
// rtl/instr_mem_loadable.sv - instruction memory with registered fetch and streamed program load
module instr_mem_loadable #(
  parameter int               WIDTH    = 16,
  parameter int               DEPTH    = 16,
  parameter int               PC_WIDTH = 16,
  parameter int               ADDR_LSB = 1,
  parameter logic [WIDTH-1:0] NOP      = '0
) (
  input logic                clk,
  input logic                rst,
  instr_mem_loadable_if.slave bus
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);
  // first byte address past the end of the array
  localparam longint unsigned PC_LIMIT = longint'(DEPTH) << ADDR_LSB;
  // pc bits that must be zero for a word-aligned fetch
  localparam logic [PC_WIDTH-1:0] ALIGN_MASK = PC_WIDTH'((64'd1 << ADDR_LSB) - 64'd1);

  typedef enum logic [1:0] {
    S_CLEAR,
    S_READY,
    S_LOAD
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            wr_en;
  logic [WIDTH-1:0] wr_data;
  logic            done_d;

  logic [WIDTH-1:0] mem [DEPTH];

  logic            fetch_fault;
  logic [AW-1:0]   fetch_index;

  assign fetch_fault = (64'(bus.pc) >= PC_LIMIT) || ((bus.pc & ALIGN_MASK) != '0);
  assign fetch_index = bus.pc[ADDR_LSB +: AW];

  // handshake and status are pure state decodes
  assign bus.load_ready = (state_q == S_LOAD);
  assign bus.busy       = (state_q != S_READY);

  // state, pointer and load-completion pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_CLEAR;
      ptr_q         <= '0;
      bus.load_done <= 1'b0;
    end else begin
      state_q       <= state_d;
      ptr_q         <= ptr_d;
      bus.load_done <= done_d;
    end
  end

  // next state: sweep NOP over the array, idle, or accept streamed words
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    wr_en   = 1'b0;
    wr_data = NOP;
    done_d  = 1'b0;
    case (state_q)
      S_CLEAR: begin
        wr_en = 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = S_READY;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + 1'b1;
        end
      end
      S_READY: begin
        if (bus.load_start) begin
          state_d = S_LOAD;
          ptr_d   = '0;
        end
      end
      S_LOAD: begin
        if (bus.load_valid) begin
          wr_en   = 1'b1;
          wr_data = bus.load_data;
          // the final array slot ends the load even without load_last
          if (bus.load_last || ptr_q == LAST_PTR) begin
            state_d = S_READY;
            ptr_d   = '0;
            done_d  = 1'b1;
          end else begin
            ptr_d = ptr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_CLEAR;
        ptr_d   = '0;
      end
    endcase
  end

  // single write port; a reset edge suppresses any pending load write
  always_ff @(posedge clk) begin
    if (wr_en && !rst) begin
      mem[ptr_q] <= wr_data;
    end
  end

  // registered fetch; only READY services requests, so reads never meet writes
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.instruction <= NOP;
      bus.instr_valid <= 1'b0;
      bus.addr_fault  <= 1'b0;
    end else if (state_q == S_READY && bus.fetch_req) begin
      bus.instr_valid <= 1'b1;
      bus.addr_fault  <= fetch_fault;
      bus.instruction <= fetch_fault ? NOP : mem[fetch_index];
    end else begin
      bus.instr_valid <= 1'b0;
      bus.addr_fault  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// tb/tb_instr_mem_loadable.sv - randomized model-checked bench for instr_mem_loadable
module tb_instr_mem_loadable;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  instr_mem_loadable_if #(.WIDTH(16), .PC_WIDTH(16)) bus ();

  instr_mem_loadable #(
    .WIDTH(16), .DEPTH(16), .PC_WIDTH(16), .ADDR_LSB(1), .NOP(16'h0000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // reference: 16-word array, clear countdown, load cursor
  logic [15:0] m_mem [16];
  int          m_clear_left = 0;
  bit          m_loading = 0;
  int          m_widx = 0;
  logic [15:0] m_instr = 16'h0;
  bit          m_valid = 0, m_fault = 0, m_done = 0;
  bit          chk_en = 0;

  always @(posedge clk) begin
    if (rst) begin
      chk_en       = 1;
      m_clear_left = 16;
      m_loading    = 0;
      m_widx       = 0;
      m_valid      = 0;
      m_fault      = 0;
      m_done       = 0;
      m_instr      = 16'h0;
      foreach (m_mem[i]) m_mem[i] = 16'h0;
    end else begin
      m_valid = 0;
      m_fault = 0;
      m_done  = 0;
      if (m_clear_left > 0) begin
        m_clear_left--;
      end else if (m_loading) begin
        if (bus.load_valid) begin
          m_mem[m_widx] = bus.load_data;
          m_widx++;
          if (bus.load_last || m_widx == 16) begin
            m_loading = 0;
            m_done    = 1;
          end
        end
      end else begin
        if (bus.fetch_req) begin
          m_valid = 1;
          m_fault = (bus.pc >= 16'h0020) || (bus.pc % 2 != 0);
          m_instr = m_fault ? 16'h0 : m_mem[bus.pc / 2];
        end
        if (bus.load_start) begin
          m_loading = 1;
          m_widx    = 0;
        end
      end
    end
  end

  // every-cycle comparison against the reference
  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("busy",        32'(bus.busy),        32'((m_clear_left > 0) || m_loading));
      chk("load_ready",  32'(bus.load_ready),  32'(m_loading));
      chk("load_done",   32'(bus.load_done),   32'(m_done));
      chk("instr_valid", 32'(bus.instr_valid), 32'(m_valid));
      chk("addr_fault",  32'(bus.addr_fault),  32'(m_fault));
      chk("instruction", 32'(bus.instruction), 32'(m_instr));
    end
  end

  logic [15:0] ld_q [$];

  task automatic idle_inputs();
    bus.fetch_req  = 0;
    bus.pc         = 16'h0;
    bus.load_start = 0;
    bus.load_valid = 0;
    bus.load_last  = 0;
    bus.load_data  = 16'h0;
  endtask

  task automatic reset_and_count();
    int n = 0;
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.busy === 1'b1) n++;
      @(negedge clk);
    end
    chk("clear_cycles", 32'(n), 32'd16);
  endtask

  task automatic fetch(input logic [15:0] a, input logic [15:0] exp, input bit expf);
    @(negedge clk);
    bus.fetch_req = 1;
    bus.pc        = a;
    @(posedge clk);
    #1;
    bus.fetch_req = 0;
    chk("lit_valid", 32'(bus.instr_valid), 32'd1);
    chk("lit_instr", 32'(bus.instruction), 32'(exp));
    chk("lit_fault", 32'(bus.addr_fault), 32'(expf));
  endtask

  task automatic start_load();
    @(negedge clk);
    bus.load_start = 1;
    @(posedge clk);
    #1;
    bus.load_start = 0;
  endtask

  task automatic load_seq(input int n, input bit use_last, input int gap_at, input int gap_len,
                          input bit expect_end);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        bus.load_valid = 0;
        repeat (gap_len) @(posedge clk);
      end
      @(negedge clk);
      bus.load_valid = 1;
      bus.load_data  = ld_q[i];
      bus.load_last  = use_last && (i == n - 1);
      @(posedge clk);
      #1;
      bus.load_valid = 0;
      bus.load_last  = 0;
    end
    if (expect_end) begin
      chk("lit_done_pulse", 32'(bus.load_done), 32'd1);
      chk("lit_busy_drop",  32'(bus.busy), 32'd0);
      chk("lit_ready_drop", 32'(bus.load_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("lit_done_single", 32'(bus.load_done), 32'd0);
    end
  endtask

  initial begin
    idle_inputs();
    reset_and_count();
    chk("lit_ready_after_clear", 32'(bus.busy), 32'd0);
    fetch(16'h0000, 16'h0000, 0);
    fetch(16'h001E, 16'h0000, 0);

    // three-word program with a two-cycle gap before the second word
    start_load();
    ld_q = '{16'h8180, 16'h0530, 16'hDC67};
    load_seq(3, 1, 1, 2, 1);
    fetch(16'h0000, 16'h8180, 0);
    fetch(16'h0002, 16'h0530, 0);
    fetch(16'h0004, 16'hDC67, 0);
    fetch(16'h0006, 16'h0000, 0);
    fetch(16'h0020, 16'h0000, 1);
    fetch(16'h0003, 16'h0000, 1);
    fetch(16'h0002, 16'h0530, 0);

    // fetch and load_start together, then fetches held during the load
    @(negedge clk);
    bus.fetch_req  = 1;
    bus.pc         = 16'h0002;
    bus.load_start = 1;
    @(posedge clk);
    #1;
    bus.load_start = 0;
    chk("lit_pre_load_valid", 32'(bus.instr_valid), 32'd1);
    chk("lit_pre_load_instr", 32'(bus.instruction), 32'h0530);
    @(posedge clk);
    #1;
    chk("lit_fetch_in_load", 32'(bus.instr_valid), 32'd0);
    ld_q = '{16'h8180, 16'hFFFF};
    load_seq(2, 1, -1, 0, 1);
    bus.fetch_req = 0;
    fetch(16'h0002, 16'hFFFF, 0);

    // full-depth load ending without load_last
    start_load();
    ld_q = {};
    for (int i = 0; i < 16; i++) ld_q.push_back(16'h1000 + 16'(i));
    load_seq(16, 0, -1, 0, 1);
    fetch(16'h001E, 16'h100F, 0);
    fetch(16'h0000, 16'h1000, 0);

    // reset in the middle of a load discards the image
    start_load();
    ld_q = '{16'hAAAA, 16'hBBBB, 16'hCCCC, 16'hDDDD, 16'hEEEE};
    load_seq(5, 0, -1, 0, 0);
    reset_and_count();
    for (int a = 0; a <= 16'h1E; a += 2) fetch(16'(a), 16'h0000, 0);

    // randomized traffic, reference model checks every cycle
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      rst            = ($urandom_range(0, 299) == 0);
      bus.fetch_req  = $urandom_range(0, 1);
      bus.pc         = ($urandom_range(0, 3) != 0) ? 16'($urandom_range(0, 16'h23)) : 16'($urandom);
      bus.load_start = ($urandom_range(0, 19) == 0);
      bus.load_valid = $urandom_range(0, 1);
      bus.load_last  = ($urandom_range(0, 7) == 0);
      bus.load_data  = 16'($urandom);
    end
    @(negedge clk);
    rst = 0;
    idle_inputs();
    repeat (40) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
